// File: rtl/alu_seq_pkg.sv
// Purpose : shared encodings for the sequential ALU / bit-count unit.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: 4-bit ALU control codes, ALUOp codes, FSM state enum, helper.
package alu_seq_pkg;

  // 4-bit internal ALU control encodings
  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_AND  = 4'b0010;
  localparam logic [3:0] CTRL_OR   = 4'b0011;
  localparam logic [3:0] CTRL_SLT  = 4'b0101;
  localparam logic [3:0] CTRL_CPOP = 4'b1000;
  localparam logic [3:0] CTRL_CLZ  = 4'b1001;
  localparam logic [3:0] CTRL_CTZ  = 4'b1010;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;

  // ALUOp field from the main controller
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_CNT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Count ops are the 1xxx codes except the illegal marker.
  function automatic logic is_count_ctrl(input logic [3:0] ctrl);
    return ctrl[3] && (ctrl != CTRL_ILL);
  endfunction

endpackage

// File: rtl/alu_seq_cnt_if.sv
// Purpose : request/response bundle between controller and sequential ALU.
// Latency : n/a (wires only).
// Backpr. : controller must hold off new requests while busy/done.
// Modports: master = controller (drives start/op/operands), slave = ALU.
interface alu_seq_cnt_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            opb5;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output start, ALUOp, funct3, funct7b5, opb5, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, ALUOp, funct3, funct7b5, opb5, a, b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Purpose : decode ALUOp/funct3/funct7b5/opb5 into the 4-bit ALU control.
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : i_aluop, i_funct3, i_funct7b5, i_opb5 in; o_ctrl out.
module alu_ctrl_dec
  import alu_seq_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_opb5,
  output logic [3:0] o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_ILL;
    case (i_aluop)
      ALUOP_ADD: o_ctrl = CTRL_ADD;
      ALUOP_SUB: o_ctrl = CTRL_SUB;
      ALUOP_RI: begin
        case (i_funct3)
          // sub only for R-type with funct7[5]; addi ignores funct7
          3'b000:  o_ctrl = (i_funct7b5 && i_opb5) ? CTRL_SUB : CTRL_ADD;
          3'b010:  o_ctrl = CTRL_SLT;
          3'b110:  o_ctrl = CTRL_OR;
          3'b111:  o_ctrl = CTRL_AND;
          default: o_ctrl = CTRL_ILL;
        endcase
      end
      ALUOP_CNT: begin
        case (i_funct3[1:0])
          2'b00:   o_ctrl = CTRL_CPOP;
          2'b01:   o_ctrl = CTRL_CLZ;
          2'b10:   o_ctrl = CTRL_CTZ;
          default: o_ctrl = CTRL_ILL;
        endcase
      end
      default: o_ctrl = CTRL_ILL;
    endcase
  end

endmodule

// File: rtl/alu_seq_cnt.sv
// Purpose : multi-cycle ALU: one-cycle add/sub/slt/or/and, iterative cpop/clz/ctz.
// Latency : 2 cycles start->done for single-cycle/illegal ops; count ops take
//           one cycle per BPC-bit chunk scanned plus one for done.
// Backpr. : start is accepted only in IDLE; ignored (not queued) otherwise.
// Ports   : clk, reset (sync, active high), bus (alu_seq_cnt_if.slave).
module alu_seq_cnt
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
)
(
  input  logic         clk,
  input  logic         reset,
  alu_seq_cnt_if.slave bus
);

  localparam int NCH = XLEN / BPC;
  localparam int CW  = $clog2(XLEN) + 1;
  localparam int IW  = $clog2(NCH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_t          r_state;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_src;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic [3:0]      w_ctrl;
  logic [XLEN-1:0] w_alu;
  logic            w_slt;
  logic [BPC-1:0]  w_chunk_hi;
  logic [BPC-1:0]  w_chunk_lo;
  logic [CW-1:0]   w_pop;
  logic [CW-1:0]   w_lz;
  logic [CW-1:0]   w_tz;
  logic [CW-1:0]   w_cnt_add;
  logic [CW-1:0]   w_cnt_nxt;
  logic [XLEN-1:0] w_cnt_ext;
  logic            w_last;
  logic            w_stop;

  alu_ctrl_dec u_dec (
    .i_aluop    (bus.ALUOp),
    .i_funct3   (bus.funct3),
    .i_funct7b5 (bus.funct7b5),
    .i_opb5     (bus.opb5),
    .o_ctrl     (w_ctrl)
  );

  // Single-cycle ALU on the captured operands
  always_comb begin
    w_slt = $signed(r_a) < $signed(r_b);
    case (r_ctrl)
      CTRL_ADD: w_alu = r_a + r_b;
      CTRL_SUB: w_alu = r_a - r_b;
      CTRL_AND: w_alu = r_a & r_b;
      CTRL_OR:  w_alu = r_a | r_b;
      CTRL_SLT: w_alu = {{(XLEN-1){1'b0}}, w_slt};
      default:  w_alu = '0;
    endcase
  end

  // Chunk examination. clz shifts the source left and looks at the top
  // chunk; cpop/ctz shift right and look at the bottom chunk.
  always_comb begin
    w_chunk_hi = r_src[XLEN-1 -: BPC];
    w_chunk_lo = r_src[BPC-1:0];
    w_pop      = '0;
    w_lz       = CW'(BPC);
    w_tz       = CW'(BPC);
    for (int i = 0; i < BPC; i++) begin
      w_pop = w_pop + {{(CW-1){1'b0}}, w_chunk_lo[i]};
      // ascending scan: the highest set bit writes last -> leading zeros
      if (w_chunk_hi[i]) w_lz = CW'(BPC - 1 - i);
      // descending scan: the lowest set bit writes last -> trailing zeros
      if (w_chunk_lo[BPC-1-i]) w_tz = CW'(BPC - 1 - i);
    end
  end

  always_comb begin
    w_last = (r_idx == LAST_IDX);
    case (r_ctrl)
      CTRL_CLZ: begin
        w_cnt_add = w_lz;
        w_stop    = w_last || (|w_chunk_hi);
      end
      CTRL_CTZ: begin
        w_cnt_add = w_tz;
        w_stop    = w_last || (|w_chunk_lo);
      end
      default: begin
        w_cnt_add = w_pop;
        w_stop    = w_last;
      end
    endcase
    w_cnt_nxt = r_cnt + w_cnt_add;
    w_cnt_ext = {{(XLEN-CW){1'b0}}, w_cnt_nxt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= CTRL_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_src     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_ctrl  <= w_ctrl;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_src   <= bus.a;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= is_count_ctrl(w_ctrl) ? ST_COUNT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result  <= w_alu;
          r_zero    <= (w_alu == '0);
          r_illegal <= (r_ctrl == CTRL_ILL);
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_COUNT: begin
          r_cnt <= w_cnt_nxt;
          r_idx <= r_idx + IW'(1);
          r_src <= (r_ctrl == CTRL_CLZ) ? (r_src << BPC) : (r_src >> BPC);
          if (w_stop) begin
            r_result  <= w_cnt_ext;
            r_zero    <= (w_cnt_nxt == '0);
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        // start in DONE is dropped; the controller re-issues from IDLE
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.zero    = r_zero;
  assign bus.illegal = r_illegal;

endmodule
